// File: rtl/uart_tx_word_arbiter.sv
// rtl/uart_tx_word_arbiter.sv - round-robin arbiter feeding 32-bit words to a byte UART, MSB first
module uart_tx_word_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int PTR_W       = 2
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   word_in,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic [PTR_W-1:0]      owner,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    input  logic                  tx_done
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [31:0]       shift;
    logic [1:0]        byte_idx;
    logic [CNT_W-1:0]  cnt;

    logic [PTR_W-1:0]  pick;
    logic              pick_vld;
    logic [31:0]       sel_word;

    // Round-robin search upward from ptr+1; iterating downward leaves the nearest hit in pick
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            int               c;
            logic [PTR_W-1:0] cidx;
            c = int'(ptr) + i;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            cidx = PTR_W'(c);
            if (req[cidx]) begin
                pick     = cidx;
                pick_vld = 1'b1;
            end
        end
    end

    // Word of the selected requester
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == PTR_W'(i)) begin
                sel_word = word_in[32*i +: 32];
            end
        end
    end

    // Arbitration and byte-sequencing FSM; every output is a register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= PTR_W'(N_REQ - 1);
            shift    <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            owner    <= '0;
            busy     <= 1'b0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
        end else begin
            grant <= '0;
            done  <= '0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (pick_vld) begin
                        shift    <= sel_word;
                        owner    <= pick;
                        ptr      <= pick;
                        grant    <= N_REQ'(1) << pick;
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_data <= shift[31:24];
                    tx_en   <= 1'b1;
                    shift   <= {shift[23:0], 8'h00};
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    tx_en <= 1'b0;
                    // tx_done during our own tx_en cycle belongs to no byte of ours yet
                    if (tx_done && !tx_en) begin
                        if (byte_idx == 2'd3) begin
                            done  <= N_REQ'(1) << owner;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= SEND;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_word_arbiter.md
Name: uart_tx_word_arbiter

Overview:
Shares one byte-wide UART transmitter between N_REQ requesters. Each requester offers a 32-bit word. The block grants requesters in round-robin order and latches the granted word. It then sends the word to the UART as four bytes, MSB first, waiting for the UART's tx_done after each byte. A per-byte watchdog aborts a word if the UART stalls. The block sits between the processor-trace/address-sort sources and the uart2 transmitter, and replaces ad-hoc per-source 32-to-8 conversion.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 65535, sys_clk cycles to wait for tx_done after a tx_en pulse before aborting the word
PTR_W, 2, width of the requester index (ceil(log2(N_REQ)), minimum 1)

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester level request; word_in slice must be valid while high
word_in  in  32*N_REQ  requester i word at bits [32*i+31:32*i]
grant  out  N_REQ  one-hot, 1-cycle pulse; word of that requester captured
done  out  N_REQ  one-hot, 1-cycle pulse; all 4 bytes of the granted word acknowledged
err  out  1  1-cycle pulse; word aborted on timeout
owner  out  PTR_W  index of the requester currently being served (valid while busy)
busy  out  1  high from grant until done/err
tx_data  out  8  byte to the UART; stable from tx_en through the matching tx_done
tx_en  out  1  1-cycle start pulse to the UART
tx_done  in  1  1-cycle pulse from the UART when the current byte has finished

Behaviour:
- All outputs are registered.
- Reset (async, reset=0):
  - state=IDLE; grant, done, err, tx_en and busy = 0; tx_data=0; owner=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - Byte index = 0; timeout counter = 0.
  - Reset asserted mid-word discards the word silently: no done, no err.
- States: IDLE, SEND, WAIT.
- IDLE:
  - On an edge where any req is high, choose the first requester with req high, searching upward from ptr+1 with wrap modulo N_REQ.
  - Latch its word into a 32-bit shift register; owner=index; ptr=index.
  - Drive grant one-hot and busy=1; byte_idx=0; go to SEND.
  - tx_done is ignored in IDLE.
- SEND (exactly 1 cycle):
  - Drive tx_data = shift[31:24] and tx_en=1 for one cycle.
  - Shift the register left 8; clear the timeout counter; go to WAIT.
  - grant returns to 0.
- WAIT:
  - tx_en=0; tx_data is held.
  - On tx_done: if byte_idx=3, pulse done[owner], set busy=0 and go to IDLE. Otherwise byte_idx+1 and go to SEND.
  - If the counter reaches TIMEOUT_CYC-1 without tx_done: pulse err, set busy=0 and go to IDLE. done is not pulsed, and ptr still advances past the owner.
  - tx_done arriving in the same cycle as the final timeout count wins: byte is treated as acknowledged, no err.
- Latency:
  - req seen at edge k gives grant high after edge k.
  - First tx_en is high after edge k+1.
  - Each tx_done gives the next tx_en 2 edges later (WAIT→SEND→tx_en).
  - done follows the 4th tx_done by one edge.
  - Minimum gap from done to the next grant is 1 cycle (one IDLE cycle).
- Requester handshake:
  - req is a level signal; the requester holds req and word_in until grant.
  - After grant the requester may change word_in freely.
  - A requester that keeps req high after grant is served again only after the other requesting sources have each had a turn.
  - req dropped before grant is legal; the request is simply not served.
- tx_done received in SEND, or while the owner's tx_en is high, is ignored; the block only samples tx_done in WAIT.
- Byte order is always [31:24], [23:16], [15:8], [7:0].
- The timeout counter is ceil(log2(TIMEOUT_CYC)) bits and saturates; it never wraps.

Test Plan:
1. Single word: req[0]=1, word_in[31:0]=0xDEADBEEF, UART model answers tx_done 10 cycles after each tx_en. Required: grant=0001, then tx_data sequence DE, AD, BE, EF with 4 tx_en pulses, then done=0001, busy=0.
2. Round robin: req=1111 held constant, words 0x11111111·i. Required: grant order 0,1,2,3,0. No byte interleaving between words; each done matches its grant.
3. Timeout: TIMEOUT_CYC=20; the UART never sends tx_done after the 2nd byte (0xAD of 0xDEADBEEF). Required: err pulses exactly 20 cycles after the 2nd tx_en, no done, busy=0, and the next requester is granted.
4. Reset mid-word: assert reset during WAIT of byte 2. Required: all outputs drop to 0 immediately (asynchronously). After release with req=0100, requester 2 is granted and its word starts from byte [31:24].
5. Edge timing:
   - tx_done pulsed during the SEND cycle and in IDLE must be ignored; byte_idx unchanged.
   - tx_done on the same cycle as the final timeout count must give a normal byte advance and no err.
6. Back-to-back: req[1] held with a new word each grant, instant tx_done (1 cycle after tx_en). Required: one byte every 3 cycles; exactly 1 IDLE cycle between done and the next grant.
